cpu_wb_master: RTL and testbench

CPU_WB_MASTER -- requirements
Module: cpu_wb_master

---
 rtl/cpu_wb_pkg.sv | 7 +
 rtl/cpu_wb_timeout.sv | 19 +
 rtl/cpu_wb_master.sv | 92 +++++++++
 tb/tb_cpu_wb_master.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_wb_pkg.sv
// cpu_wb_pkg: shared types and constants for the CPU-to-Wishbone master.
package cpu_wb_pkg;
    typedef enum logic [1:0] {IDLE, BUS, RELEASE} state_t;
    localparam logic [31:0] ERR_DATA    = 32'hDEADBEEF;
    localparam logic [3:0]  SEL_DEFAULT = 4'hF;
    localparam int          ERR_CNT_W   = 8;
endpackage

// File: rtl/cpu_wb_timeout.sv
// cpu_wb_timeout: counts bus cycles and flags expiry in the TIMEOUT-th cycle.
module cpu_wb_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    // expired is raised during the last allowed cycle so the abort lands on its closing edge
    assign expired = enable && (cnt == CW'(TIMEOUT - 1));
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/cpu_wb_master.sv
// cpu_wb_master: single-transfer CPU request to classic Wishbone master.
// Optional bus timeout abort compiled in with CPU_WB_TIMEOUT_EN.
import cpu_wb_pkg::*;

module cpu_wb_master #(
    parameter int dw      = 32,
    parameter int aw      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [aw-1:0]        cpu_address,
    input  logic                 cpu_start,
    input  logic [3:0]           cpu_selection,
    input  logic                 cpu_write,
    input  logic [dw-1:0]        cpu_data_wr,
    output logic [dw-1:0]        cpu_data_rd,
    output logic                 cpu_active,
    output logic [aw-1:0]        wb_adr_o,
    output logic [dw-1:0]        wb_dat_o,
    input  logic [dw-1:0]        wb_dat_i,
    output logic [3:0]           wb_sel_o,
    output logic                 wb_we_o,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i,
    output logic                 bus_error,
    output logic [ERR_CNT_W-1:0] error_count
);
    state_t state, state_n;
    logic start_bus, term, err_term, expired, release_done;

`ifdef CPU_WB_TIMEOUT_EN
    cpu_wb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .enable  (state == BUS),
        .clear   (start_bus),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        start_bus    = (state == IDLE) && cpu_start;
        err_term     = (state == BUS) && (wb_err_i || expired);
        term         = (state == BUS) && (wb_ack_i || wb_err_i || expired);
        release_done = (state == RELEASE) && !cpu_start;
        state_n      = start_bus    ? BUS :
                       term         ? (cpu_start ? RELEASE : IDLE) :
                       release_done ? IDLE : state;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cpu_active  <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            bus_error   <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_sel_o    <= 4'h0;
            cpu_data_rd <= '0;
            error_count <= '0;
        end else begin
            bus_error <= err_term;
            if (start_bus) begin
                wb_adr_o   <= cpu_address;
                wb_dat_o   <= cpu_data_wr;
                wb_sel_o   <= (cpu_selection == 4'h0) ? SEL_DEFAULT : cpu_selection;
                wb_we_o    <= cpu_write;
                wb_cyc_o   <= 1'b1;
                wb_stb_o   <= 1'b1;
                cpu_active <= 1'b1;
            end
            if (term) begin
                wb_cyc_o   <= 1'b0;
                wb_stb_o   <= 1'b0;
                cpu_active <= cpu_start;
                if (!wb_we_o) cpu_data_rd <= err_term ? dw'(ERR_DATA) : wb_dat_i;
            end
            if (release_done) cpu_active <= 1'b0;
            if (err_term && error_count != '1) error_count <= error_count + 1'b1;
        end
endmodule

// File: tb/tb_cpu_wb_master.sv
// tb_cpu_wb_master: randomized self-checking bench with a transaction-level model.
module tb_cpu_wb_master;
    logic        clk = 1'b0, rst;
    logic [31:0] cpu_address, cpu_data_wr, cpu_data_rd, wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  cpu_selection, wb_sel_o;
    logic        cpu_start, cpu_write, cpu_active, wb_we_o, wb_cyc_o, wb_stb_o;
    logic        wb_ack_i, wb_err_i, bus_error;
    logic [7:0]  error_count;
    int          errors = 0, checks = 0;
    logic [31:0] exp_rd;
    logic [7:0]  exp_cnt;

    always #5 clk = ~clk;

    cpu_wb_master #(.dw(32), .aw(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .cpu_address(cpu_address), .cpu_start(cpu_start),
        .cpu_selection(cpu_selection), .cpu_write(cpu_write), .cpu_data_wr(cpu_data_wr),
        .cpu_data_rd(cpu_data_rd), .cpu_active(cpu_active), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .bus_error(bus_error), .error_count(error_count)
    );

    // One complete transfer; the slave answers in BUS cycle dly+1, requester holds start hold cycles past it
    task automatic txn(input logic [31:0] a, d, rv, input logic [3:0] s,
                       input logic we, err, both, input int dly, hold);
        logic [3:0] es;
        es = (s == 4'h0) ? 4'hF : s;
        cpu_address = a; cpu_data_wr = d; cpu_selection = s; cpu_write = we; cpu_start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({wb_cyc_o, wb_stb_o, cpu_active, wb_we_o, wb_sel_o} !== {3'b111, we, es}) begin
            errors++;
            $display("FAIL txn_start: cyc/stb/act/we/sel got %b want %b",
                     {wb_cyc_o, wb_stb_o, cpu_active, wb_we_o, wb_sel_o}, {3'b111, we, es});
        end
        checks++;
        if ({wb_adr_o, wb_dat_o} !== {a, d}) begin
            errors++;
            $display("FAIL txn_addr_data: got %h/%h want %h/%h", wb_adr_o, wb_dat_o, a, d);
        end
        for (int i = 0; i < dly; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({wb_cyc_o, cpu_active} !== 2'b11) begin
                errors++;
                $display("FAIL txn_wait: cyc/act got %b want 11", {wb_cyc_o, cpu_active});
            end
        end
        wb_dat_i = rv; wb_ack_i = !err || both; wb_err_i = err;
        if (hold == 0) cpu_start = 1'b0;
        @(posedge clk); #1;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
        if (err && exp_cnt != 8'hFF) exp_cnt++;
        if (!we) exp_rd = err ? 32'hDEADBEEF : rv;
        checks++;
        if ({wb_cyc_o, wb_stb_o, bus_error, cpu_active} !== {2'b00, err, hold != 0}) begin
            errors++;
            $display("FAIL txn_term: cyc/stb/err/act got %b want %b",
                     {wb_cyc_o, wb_stb_o, bus_error, cpu_active}, {2'b00, err, hold != 0});
        end
        checks++;
        if ({cpu_data_rd, error_count} !== {exp_rd, exp_cnt}) begin
            errors++;
            $display("FAIL txn_result: rd/cnt got %h/%0d want %h/%0d", cpu_data_rd, error_count, exp_rd, exp_cnt);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({wb_cyc_o, bus_error, cpu_active} !== 3'b001) begin
                errors++;
                $display("FAIL txn_hold: cyc/err/act got %b want 001", {wb_cyc_o, bus_error, cpu_active});
            end
        end
        cpu_start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({wb_cyc_o, bus_error, cpu_active, cpu_data_rd} !== {3'b000, exp_rd}) begin
            errors++;
            $display("FAIL txn_idle: cyc/err/act/rd got %b/%h want 000/%h",
                     {wb_cyc_o, bus_error, cpu_active}, cpu_data_rd, exp_rd);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; cpu_start = 0; cpu_address = 0; cpu_selection = 0; cpu_write = 0;
        cpu_data_wr = 0; wb_dat_i = 0; wb_ack_i = 0; wb_err_i = 0;
        exp_rd = 0; exp_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cpu_active, wb_cyc_o, wb_stb_o, wb_we_o, bus_error, wb_sel_o} !== 9'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0", {cpu_active, wb_cyc_o, wb_stb_o, wb_we_o, bus_error, wb_sel_o});
        end
        checks++;
        if ({wb_adr_o, wb_dat_o, cpu_data_rd, error_count} !== 104'd0) begin
            errors++;
            $display("FAIL reset_data: adr %h dat %h rd %h cnt %0d want all 0", wb_adr_o, wb_dat_o, cpu_data_rd, error_count);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write;
        txn(32'h100, 32'h12345678, 32'h0BADF00D, 4'h0, 1'b1, 1'b0, 1'b0, 2, 0);
        txn(32'h104, 32'hA5A5A5A5, 32'h0, 4'h3, 1'b1, 1'b0, 1'b0, 0, 1);
    endtask

    task automatic test_read;
        txn(32'h200, 32'h0, 32'hCAFEF00D, 4'h0, 1'b0, 1'b0, 1'b0, 1, 0);
    endtask

    task automatic test_error;
        txn(32'h300, 32'h0, 32'h11111111, 4'h0, 1'b0, 1'b1, 1'b0, 0, 0);
        txn(32'h304, 32'h0, 32'h22222222, 4'h8, 1'b0, 1'b1, 1'b1, 1, 0);
        for (int i = 0; i < 300; i++)
            txn($urandom, $urandom, $urandom, 4'($urandom), 1'($urandom), 1'b1, 1'($urandom), 0, 0);
        checks++;
        if (error_count !== 8'hFF) begin
            errors++;
            $display("FAIL error_saturate: got %h want ff", error_count);
        end
    endtask

    task automatic test_hold;
        txn(32'h400, 32'h55AA55AA, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 0, 5);
        txn(32'h404, 32'h0, 32'h76543210, 4'hC, 1'b0, 1'b0, 1'b0, 2, 5);
    endtask

    task automatic test_idle_ack;
        wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'h99999999;
        repeat (2) @(posedge clk);
        #1;
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        checks++;
        if ({wb_cyc_o, bus_error, cpu_active, cpu_data_rd, error_count} !== {3'b000, exp_rd, exp_cnt}) begin
            errors++;
            $display("FAIL idle_ack: cyc/err/act %b rd %h cnt %0d want 000 %h %0d",
                     {wb_cyc_o, bus_error, cpu_active}, cpu_data_rd, error_count, exp_rd, exp_cnt);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++)
            txn($urandom, $urandom, $urandom, 4'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                1'($urandom), $urandom_range(0, 4), $urandom_range(0, 3));
    endtask

    task automatic test_timeout;
        cpu_address = 32'h500; cpu_write = 1'b0; cpu_selection = 4'h0; cpu_start = 1'b1;
        @(posedge clk); #1;
        cpu_start = 1'b0;
`ifdef CPU_WB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            checks++;
            if (wb_cyc_o !== 1'b1) begin
                errors++;
                $display("FAIL timeout_early: cycle %0d cyc got %b want 1", i + 2, wb_cyc_o);
            end
        end
        @(posedge clk); #1;
        if (exp_cnt != 8'hFF) exp_cnt++;
        exp_rd = 32'hDEADBEEF;
        checks++;
        if ({wb_cyc_o, bus_error, cpu_active, cpu_data_rd, error_count} !== {3'b010, exp_rd, exp_cnt}) begin
            errors++;
            $display("FAIL timeout_abort: cyc/err/act %b rd %h cnt %0d want 010 %h %0d",
                     {wb_cyc_o, bus_error, cpu_active}, cpu_data_rd, error_count, exp_rd, exp_cnt);
        end
`else
        repeat (1000) @(posedge clk);
        #1;
        checks++;
        if ({wb_cyc_o, cpu_active} !== 2'b11) begin
            errors++;
            $display("FAIL no_timeout: cyc/act got %b want 11", {wb_cyc_o, cpu_active});
        end
        wb_ack_i = 1'b1; wb_dat_i = 32'h13572468;
        @(posedge clk); #1;
        wb_ack_i = 1'b0;
        exp_rd = 32'h13572468;
        checks++;
        if ({wb_cyc_o, cpu_active, cpu_data_rd} !== {2'b00, exp_rd}) begin
            errors++;
            $display("FAIL no_timeout_ack: cyc/act %b rd %h want 00 %h", {wb_cyc_o, cpu_active}, cpu_data_rd, exp_rd);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        cpu_address = 32'h600; cpu_data_wr = 32'hFEEDFACE; cpu_write = 1'b1; cpu_start = 1'b1;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        exp_rd = 0; exp_cnt = 0;
        checks++;
        if ({wb_cyc_o, wb_stb_o, cpu_active, cpu_data_rd, error_count} !== {3'b000, exp_rd, exp_cnt}) begin
            errors++;
            $display("FAIL reset_mid: cyc/stb/act %b rd %h cnt %0d want 000 0 0",
                     {wb_cyc_o, wb_stb_o, cpu_active}, cpu_data_rd, error_count);
        end
        cpu_start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({wb_cyc_o, cpu_active} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: cyc/act got %b want 00", {wb_cyc_o, cpu_active});
        end
        txn(32'h700, 32'h0F0F0F0F, 32'h0, 4'h5, 1'b1, 1'b0, 1'b0, 1, 0);
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_error;
        test_hold;
        test_idle_ack;
        test_random;
        test_timeout;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
